// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stall, branch flush, mult/div start/wait FSM.
// Outputs are combinational from state and inputs; stalls hold upstream stages, nothing ever backpressures this block.
module hazard_control #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_X,
  input  logic        branch_taken,
  input  logic        data_resultRDY,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_X,
  output logic        nop_X,
  output logic        nop_M,
  output logic        flush_D,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_timeout,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_START = 2'd1,
    MD_BUSY  = 2'd2,
    MD_DONE  = 2'd3
  } state_t;

  // Counter saturates at 63, so larger timeouts clamp to the saturated value.
  localparam int          LAST_I = (MD_TIMEOUT < 1) ? 0 : ((MD_TIMEOUT > 64) ? 63 : MD_TIMEOUT - 1);
  localparam logic [5:0]  C_LAST = 6'(LAST_I);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_wait_cnt;
  logic        r_md_div;
  logic        r_md_timeout;
  logic [31:0] r_stall_cnt;

  logic [4:0] w_d_op, w_d_rd, w_d_rs, w_d_rt;
  logic [4:0] w_x_op, w_x_rd, w_x_alu;
  logic       w_d_rtype, w_d_sw, w_d_br;
  logic       w_x_rtype, w_x_lw, w_x_mul, w_x_div;
  logic       w_hit_rs, w_hit_rt, w_hit_rd, w_load_use;
  logic       w_cnt_last;
  logic       w_stall_f, w_stall_d, w_stall_x, w_nop_x, w_nop_m, w_flush_d, w_mult, w_div;
  logic       w_unused;

  assign w_d_op  = IR_D[31:27];
  assign w_d_rd  = IR_D[26:22];
  assign w_d_rs  = IR_D[21:17];
  assign w_d_rt  = IR_D[16:12];
  assign w_x_op  = IR_X[31:27];
  assign w_x_rd  = IR_X[26:22];
  assign w_x_alu = IR_X[6:2];
  assign w_unused = ^{IR_D[11:0], IR_X[21:7], IR_X[1:0]};

  assign w_d_rtype = (w_d_op == 5'b00000);
  assign w_d_sw    = (w_d_op == 5'b00111);
  assign w_d_br    = (w_d_op == 5'b00010) || (w_d_op == 5'b00110);
  assign w_x_rtype = (w_x_op == 5'b00000);
  assign w_x_lw    = (w_x_op == 5'b01000);
  assign w_x_mul   = w_x_rtype && (w_x_alu == 5'b00110);
  assign w_x_div   = w_x_rtype && (w_x_alu == 5'b00111);

  assign w_hit_rs   = (w_d_rs == w_x_rd);
  assign w_hit_rt   = w_d_rtype && (w_d_rt == w_x_rd);
  assign w_hit_rd   = (w_d_sw || w_d_br) && (w_d_rd == w_x_rd);
  assign w_load_use = w_x_lw && (w_x_rd != 5'd0) && (w_hit_rs || w_hit_rt || w_hit_rd);

  assign w_cnt_last = (r_wait_cnt >= C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_x   = 1'b0;
    w_nop_x     = 1'b0;
    w_nop_m     = 1'b0;
    w_flush_d   = 1'b0;
    w_mult      = 1'b0;
    w_div       = 1'b0;
    case (r_state)
      IDLE: begin
        if (branch_taken) begin
          w_flush_d = 1'b1;
          w_nop_x   = 1'b1;
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_nop_x   = 1'b1;
        end
        if (w_x_mul || w_x_div) w_state_nxt = MD_START;
      end
      MD_START: begin
        w_stall_f   = 1'b1;
        w_stall_d   = 1'b1;
        w_stall_x   = 1'b1;
        w_nop_m     = 1'b1;
        w_mult      = ~r_md_div;
        w_div       = r_md_div;
        w_state_nxt = data_resultRDY ? MD_DONE : MD_BUSY;
      end
      MD_BUSY: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_x = 1'b1;
        w_nop_m   = 1'b1;
        if (data_resultRDY || w_cnt_last) w_state_nxt = MD_DONE;
      end
      MD_DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 6'd0;
      r_md_div     <= 1'b0;
      r_md_timeout <= 1'b0;
      r_stall_cnt  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      // Op kind is captured on entry so the pulse is right even if IR_X moves on.
      if (r_state == IDLE && w_state_nxt == MD_START) begin
        r_wait_cnt <= 6'd0;
        r_md_div   <= w_x_div;
      end else if (r_state == MD_BUSY && r_wait_cnt != 6'h3F) begin
        r_wait_cnt <= r_wait_cnt + 6'd1;
      end
      if (r_state == MD_BUSY && !data_resultRDY && w_cnt_last) r_md_timeout <= 1'b1;
      if (w_stall_f) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Gating with reset drops combinational outputs the instant reset asserts.
  assign stall_F     = reset & w_stall_f;
  assign stall_D     = reset & w_stall_d;
  assign stall_X     = reset & w_stall_x;
  assign nop_X       = reset & w_nop_x;
  assign nop_M       = reset & w_nop_m;
  assign flush_D     = reset & w_flush_d;
  assign ctrl_MULT   = reset & w_mult;
  assign ctrl_DIV    = reset & w_div;
  assign md_timeout  = r_md_timeout;
  assign stall_count = r_stall_cnt;

endmodule
